bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side initiator for the word-addressed BRAM port: drives bram_addr/bram_we/bram_wrdata and consumes bram_rddata (1-cycle registered read latency).
- On start, fetches num_words consecutive 32-bit words from base_addr and presents them on a valid/ready stream.
- Used to feed weight and x/y vectors into compute blocks. Absorbs downstream backpressure with a 2-entry buffer while sustaining 1 word/cycle.

Parameters:
- BRAM_WIDTH, 32, data width of bram_rddata / m_data.
- WORD_SIZE, 4, bytes per word; address stride.
- ADDR_WIDTH, 12, BRAM byte-address width.
- LEN_WIDTH, 11, width of num_words; max transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- start  in  1  begin transfer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  byte start address; low log2(WORD_SIZE) bits ignored.
- num_words  in  LEN_WIDTH  words to read; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at transfer end.
- bram_addr  out  ADDR_WIDTH  byte address to BRAM; low bits always 0.
- bram_rddata  in  BRAM_WIDTH  BRAM read data, valid one cycle after its address.
- bram_wrdata  out  BRAM_WIDTH  constant 0.
- bram_we  out  WORD_SIZE  constant 0; the block never writes.
- m_data  out  BRAM_WIDTH  stream data (head of buffer).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; transfer on m_valid & m_ready.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, m_valid=0, m_data=0, bram_addr=0, buffer and in-flight flag cleared. Reset mid-transfer aborts it. No done pulse. Any in-flight read is discarded.
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, buffer not yet empty), DONE (1 cycle, done=1).
- IDLE: if start=1, latch base_addr (low bits zeroed) and num_words.
  - num_words=0: go to DONE, with no BRAM read and no stream beat.
  - Otherwise: go to RUN.
  - start while not IDLE is ignored.
- Issue rule, per cycle in RUN: a read issues iff (buffer occupancy + inflight − pop) < 2, where pop = m_valid & m_ready.
- On issue: bram_addr = current address. inflight is set for the next cycle. Address += WORD_SIZE, modulo 2^ADDR_WIDTH (wraps to 0). Remaining count decrements.
- When the last read issues, go to DRAIN. Without an issue, bram_addr holds its value (reads have no side effects).
- Capture: in the cycle after an issue, bram_rddata is pushed into the 2-entry FIFO at the clock edge, and inflight clears.
- The occupancy rule guarantees the FIFO never overflows. Simultaneous push and pop is legal; occupancy is unchanged.
- Stream:
  - m_valid = FIFO non-empty; m_data = FIFO head, both registered outputs.
  - While m_valid=1 and m_ready=0, m_data is held stable.
  - Words appear in address order, no drops or duplicates.
- Latency: start sampled at edge E0 → bram_addr=base in cycle E0–E1 → data captured at E2 → m_valid=1 after E2 (3 cycles start-to-first-beat).
- Throughput: with m_ready held 1, one beat per cycle, no bubbles.
- DRAIN → DONE in the cycle after the last beat's handshake, with FIFO empty and inflight=0. DONE → IDLE next cycle.
- busy=1 in RUN, DRAIN and DONE. done=1 only in DONE.
- The block never asserts bram_we; any nonzero bram_we is a bug.

Test Plan:
- BRAM words 0x100..0x10C = A0,A1,A2,A3; start, base_addr=0x100, num_words=4, m_ready=1 → m_valid first high 3 cycles after start edge. Beats A0..A3 on 4 consecutive cycles. done pulses 1 cycle after the A3 beat. bram_we=0 throughout.
- Same transfer, m_ready toggling 1,0,0,1,0,1,1 → beats still A0..A3 in order. m_data stable while stalled. bram_addr never runs more than 2 words ahead of accepted beats. No loss.
- num_words=0 → done pulses once one cycle after start. m_valid never rises. No new bram_addr value is issued.
- base_addr=0xFF8 (ADDR_WIDTH=12), num_words=4 → reads at 0xFF8, 0xFFC, 0x000, 0x004. Beats follow that order. base_addr=0x103 reads from 0x100.
- start pulsed again mid-transfer with different base_addr → ignored; original transfer completes unchanged with a single done.
- reset driven low for 1 cycle after 2 beats of an 8-word transfer → all outputs 0 immediately, no done. A new start afterwards runs a clean transfer from its own base_addr.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: fetches num_words consecutive words from a BRAM and streams them out over valid/ready
//
// Ports:
//   clk          clock, all logic on posedge
//   reset        asynchronous active-low reset
//   start        begin a transfer (sampled only when idle)
//   base_addr    byte start address, low word-offset bits ignored
//   num_words    number of words to read, sampled with start
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse at transfer end
//   bram_addr    byte address to BRAM (word aligned)
//   bram_rddata  BRAM read data, valid one cycle after its address
//   bram_wrdata  constant 0
//   bram_we      constant 0, this block never writes
//   m_data       stream data (head of the 2-entry buffer)
//   m_valid      stream valid
//   m_ready      stream ready, a beat moves on m_valid & m_ready
module bram_stream_reader #(
    parameter int BRAM_WIDTH = 32,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [BRAM_WIDTH-1:0] bram_rddata,
    output logic [BRAM_WIDTH-1:0] bram_wrdata,
    output logic [WORD_SIZE-1:0]  bram_we,
    output logic [BRAM_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN  = ~ADDR_WIDTH'(WORD_SIZE - 1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;
    logic [1:0]            count;
    logic [BRAM_WIDTH-1:0] tail;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    assign bram_wrdata = '0;
    assign bram_we     = '0;

    // occ is the buffer occupancy after this edge, counting the word still in the BRAM pipe;
    // keeping it below 2 when issuing is what guarantees the buffer never overflows
    assign pop   = m_valid & m_ready;
    assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == RUN) && (occ < 3'd2);

    // bram_addr doubles as the read pointer: it always shows the next word to fetch,
    // so the first address reaches the BRAM in the cycle right after start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_addr <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining <= num_words;
                        busy      <= 1'b1;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            bram_addr <= base_addr & ALIGN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1))
                            state <= DRAIN;
                        else
                            bram_addr <= bram_addr + STRIDE;
                    end
                end
                DRAIN: begin
                    // finish on the edge that takes the last beat so done follows it directly
                    if (occ == 3'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // two-entry buffer held as head (m_data) and tail registers; a push into a
    // full buffer cannot happen because of the issue rule above
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            count    <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            tail     <= '0;
        end else begin
            inflight <= issue;
            count    <= occ[1:0];
            m_valid  <= occ != 3'd0;
            if (pop && count == 2'd2)
                m_data <= tail;
            else if (inflight && (count == 2'd0 || pop))
                m_data <= bram_rddata;
            else if (inflight)
                tail <= bram_rddata;
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized self-checking bench for bram_stream_reader
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        m_ready = 1'b0;
    logic [11:0] base_addr = '0;
    logic [10:0] num_words = '0;
    logic        busy, done, m_valid;
    logic [11:0] bram_addr;
    logic [31:0] bram_rddata, bram_wrdata, m_data;
    logic [3:0]  bram_we;
    logic [31:0] mem [1024];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) bram_rddata <= mem[bram_addr[11:2]];

    bram_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_rddata(bram_rddata),
        .bram_wrdata(bram_wrdata), .bram_we(bram_we), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_valid, bram_addr, m_data, bram_we, bram_wrdata} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b m_valid=%b bram_addr=%h m_data=%h we=%h, required all 0",
                     busy, done, m_valid, bram_addr, m_data, bram_we);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // mode 0: m_ready held high, 1: pattern 1,0,0,1,0,1,1 over valid cycles, 2: random
    task automatic do_transfer(input string name, input logic [11:0] base, input int n, input int mode, input bit mid);
        logic [31:0] exp_q[$];
        logic [11:0] exp_a[$];
        logic [6:0]  pat = 7'b1101001;
        logic [11:0] pre_addr, last_addr;
        logic [31:0] pd = '0;
        logic        pv = 1'b0, pr = 1'b0;
        int beats = 0, ai = 0, cyc = 0, done_cnt = 0, pi = 0;
        int first_v = -1, first_b = -1, last_b = -1, exp_done;
        last_addr = '0;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(12'((base & 12'hFFC) + 4 * i));
            exp_q.push_back(mem[exp_a[i][11:2]]);
        end
        @(negedge clk);
        pre_addr = bram_addr;
        start = 1'b1;
        base_addr = base;
        num_words = 11'(n);
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (done_cnt == 0 && cyc < 400) begin
            cyc++;
            if (mid && cyc == 4) begin
                start = 1'b1;
                base_addr = base + 12'h040;
                num_words = 11'd3;
            end
            if (mid && cyc == 5) start = 1'b0;
            checks++;
            if (bram_we !== '0 || bram_wrdata !== '0) begin
                fails++;
                $display("FAIL %s no_write: bram_we=%h bram_wrdata=%h, required 0", name, bram_we, bram_wrdata);
            end
            checks++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL %s busy: cycle %0d busy=%b, required 1", name, cyc, busy);
            end
            if (n == 0) begin
                checks++;
                if (bram_addr !== pre_addr || m_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s zero_len: bram_addr=%h m_valid=%b, required %h and 0", name, bram_addr, m_valid, pre_addr);
                end
            end else if (cyc == 1) begin
                checks++;
                if (bram_addr !== exp_a[0]) begin
                    fails++;
                    $display("FAIL %s first_addr: bram_addr=%h, required %h", name, bram_addr, exp_a[0]);
                end
                ai = 1;
                last_addr = bram_addr;
            end else if (bram_addr !== last_addr) begin
                checks++;
                if (ai >= n || bram_addr !== exp_a[ai]) begin
                    fails++;
                    $display("FAIL %s addr_seq: read %0d bram_addr=%h, required %h", name, ai, bram_addr,
                             ai < n ? exp_a[ai] : 12'hxxx);
                end
                ai++;
                last_addr = bram_addr;
            end
            if (n > 0) begin
                checks++;
                if (ai - 1 - beats > 2) begin
                    fails++;
                    $display("FAIL %s addr_ahead: address index %0d with %0d beats accepted, required at most 2 ahead", name, ai - 1, beats);
                end
            end
            if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd) begin
                    fails++;
                    $display("FAIL %s stall_hold: m_valid=%b m_data=%h, required 1 and %h", name, m_valid, m_data, pd);
                end
            end
            if (m_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (done === 1'b1) begin
                done_cnt++;
                exp_done = (n == 0) ? 1 : last_b + 1;
                checks++;
                if (cyc != exp_done || beats != n) begin
                    fails++;
                    $display("FAIL %s done_timing: done at cycle %0d after %0d beats, required cycle %0d after %0d beats",
                             name, cyc, beats, exp_done, n);
                end
            end
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[pi % 7] : 1'($urandom_range(0, 1));
            if (m_valid === 1'b1) pi++;
            if (m_valid === 1'b1 && m_ready) begin
                checks++;
                if (beats >= n || m_data !== exp_q[beats]) begin
                    fails++;
                    $display("FAIL %s beat: beat %0d m_data=%h, required %h", name, beats, m_data,
                             beats < n ? exp_q[beats] : 32'hxxxxxxxx);
                end
                if (first_b < 0) first_b = cyc;
                beats++;
                last_b = cyc;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        checks++;
        if (beats != n || ai != n) begin
            fails++;
            $display("FAIL %s totals: %0d beats %0d addresses, required %0d each", name, beats, ai, n);
        end
        if (n > 0) begin
            checks++;
            if (first_v != 3) begin
                fails++;
                $display("FAIL %s latency: m_valid first at cycle %0d, required 3", name, first_v);
            end
        end
        if (mode == 0 && n > 0) begin
            checks++;
            if (last_b - first_b != n - 1) begin
                fails++;
                $display("FAIL %s throughput: beats spanned %0d cycles, required %0d", name, last_b - first_b + 1, n);
            end
        end
        repeat (3) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s idle_after: done=%b busy=%b m_valid=%b, required 0", name, done, busy, m_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic;
        do_transfer("basic", 12'h100, 4, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_transfer("backpressure", 12'h100, 4, 1, 1'b0);
        do_transfer("backpressure_long", 12'h180, 9, 1, 1'b0);
    endtask

    task automatic test_zero_len;
        do_transfer("zero_len", 12'h200, 0, 0, 1'b0);
    endtask

    task automatic test_wrap;
        do_transfer("wrap", 12'hFF8, 4, 0, 1'b0);
        do_transfer("unaligned", 12'h103, 4, 2, 1'b0);
    endtask

    task automatic test_mid_start;
        do_transfer("mid_start", 12'h100, 6, 2, 1'b1);
    endtask

    task automatic test_reset_mid;
        int beats = 0, cyc = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 12'h300;
        num_words = 11'd8;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < 2 && cyc < 50) begin
            cyc++;
            if (m_valid === 1'b1) begin
                checks++;
                if (m_data !== mem[12'hC0 + beats]) begin
                    fails++;
                    $display("FAIL reset_mid beat: m_data=%h, required %h", m_data, mem[12'hC0 + beats]);
                end
                beats++;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_valid, bram_addr, m_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs: busy=%b done=%b m_valid=%b bram_addr=%h m_data=%h, required all 0",
                     busy, done, m_valid, bram_addr, m_data);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid quiet: done=%b m_valid=%b busy=%b, required 0", done, m_valid, busy);
            end
        end
        do_transfer("after_reset", 12'h340, 5, 2, 1'b0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++)
            do_transfer("random", 12'($urandom_range(0, 4095)), $urandom_range(1, 12), 2, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[64 + i] = 32'hA0 + i;
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_len;
        test_wrap;
        test_mid_start;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
